uart_rx_deserializer: RTL
=========================

Name: uart_rx_deserializer

Overview:
- Receive front end of the UART: oversamples the asynchronous rx pin, detects and validates the start bit, deserializes 5-8 data bits plus optional parity and 1-2 stop bits.
- Presents each completed character as a one-cycle write strobe into the 8-bit rx FIFO, with error flags.
- Sits between the rx pad and the rx queue; its sample tick comes from the UART's 16x main clock divider.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be a power of two, >= 8.
- DATA_WIDTH, 8, width of data output; maximum data bits per character.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sample_tick  input  1  one-clk-wide enable at OVERSAMPLE x baud rate.
- rx  input  1  raw serial line; asynchronous to clk, idle high.
- data_bits_count  input  2  data bits per character = value + 5.
- parity_type  input  2  00 none, 01 even, 10 odd, 11 none.
- double_stop_bits  input  1  1 = two stop bits expected.
- fifo_full  input  1  rx FIFO full flag.
- data  output  DATA_WIDTH  received character, right-aligned, unused upper bits 0.
- valid  output  1  one-clk pulse; data/flags are valid; drives FIFO we.
- parity_err  output  1  qualified by valid.
- frame_err  output  1  qualified by valid; a stop bit was sampled 0.
- overrun  output  1  one-clk pulse; character dropped because fifo_full.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, synchronizer flops 1, counters 0. Takes effect mid-frame; the partial character is discarded.
- rx is passed through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
- Counters: tick_cnt is log2(OVERSAMPLE) bits and wraps naturally; bit_cnt is 3 bits. Both advance only on sample_tick.
- IDLE: on sample_tick with rxs=0, latch the config inputs into internal registers, clear tick_cnt, go to START. Config changes mid-frame are ignored.
- START: on the tick where tick_cnt = OVERSAMPLE/2-1 (bit midpoint), sample rxs.
  - rxs=1: false start; go to IDLE, no output.
  - rxs=0: clear tick_cnt and bit_cnt, go to DATA.
- DATA: on each tick with tick_cnt = OVERSAMPLE-1, sample rxs into shift position bit_cnt (LSB first), then increment bit_cnt.
  - After the last data bit (bit_cnt = latched count-1), go to PARITY if parity is enabled, else STOP1.
- PARITY: sample at tick_cnt = OVERSAMPLE-1.
  - even: error if XOR(data bits, parity bit) = 1.
  - odd: error if that XOR = 0.
  - Store the error, go to STOP1.
- STOP1: sample at tick_cnt = OVERSAMPLE-1; rxs=0 sets the frame error. Go to STOP2 if double_stop_bits latched, else DONE.
- STOP2: same sample rule as STOP1, ORing into the frame error; then DONE.
- DONE (single clk): if fifo_full=0, assert valid with data/parity_err/frame_err; else assert overrun and leave valid at 0. Go to IDLE.
- Sampling at mid-bit means IDLE is re-entered half a bit before the line's stop bit ends; back-to-back frames must be received without loss.
- Latency: valid rises exactly 2 clk after the sample_tick that samples the last stop bit (1 clk into DONE, 1 clk registered outputs).
- data, parity_err and frame_err hold their values between strobes; valid and overrun are pulses only.
- busy = 1 in every state except IDLE.
- sample_tick asserted on consecutive clks is legal; every tick counts.

Decomposition:
- Package uart_pkg holds:
  - the parity_type encoding enum;
  - the rx state enum (IDLE, START, DATA, PARITY, STOP1, STOP2, DONE);
  - the constant DATA_BITS_OFFSET = 5.
- One natural sub-module: sync_2ff (parameterized reset value, here 1), reusable for any asynchronous input.

Test Plan (sample_tick every 4 clk, OVERSAMPLE=16, so 64 clk per bit):
- 8N1 (cnt=3, parity=00, 1 stop), send 0xA5 -> one valid pulse, data=0xA5, parity_err=0, frame_err=0, overrun=0, busy low afterward.
- 5 bits, even parity (cnt=0, parity=01), send 0x13 with parity bit 1 -> data=0x13, parity_err=0. Resend with parity bit 0 -> parity_err=1, data=0x13.
- Glitch: rx low for 4 ticks then high -> no valid, busy falls at the midpoint sample. Then 7O2 frame 0x41 with correct parity -> data=0x41, no errors.
- 8N2, second stop bit driven 0, data 0xFF -> valid with data=0xFF, frame_err=1. Two back-to-back 8N1 frames 0x00, 0x7E -> two valid pulses in order.
- fifo_full=1 during DONE, send 0x55 -> valid never asserted, overrun single pulse. Deassert fifo_full, send 0x56 -> valid with data=0x56.
- Drop reset to 0 during the 3rd data bit -> all outputs 0 asynchronously, no valid. Release reset, send 0xC3 -> data=0xC3 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity encoding, receiver state machine states, data-width offset.
package uart_pkg;

  localparam int DATA_BITS_OFFSET = 5;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high lines come up inactive.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: start-bit check, 5-8 data bits,
// optional parity, 1-2 stop bits, one-cycle FIFO write strobe.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  rx,
  input  logic [1:0]            data_bits_count,
  input  logic [1:0]            parity_type,
  input  logic                  double_stop_bits,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic rxs;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

  rx_state_e             state_q;
  logic [TW-1:0]         tick_q;
  logic [2:0]            bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            dbits_q;
  parity_e               ptype_q;
  logic                  dstop_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  valid_q;
  logic                  pe_q;
  logic                  fe_q;
  logic                  ovr_q;

  logic mid_hit;
  logic bit_hit;
  logic last_bit;
  logic par_en;

  assign mid_hit  = sample_tick && (tick_q == MID);
  assign bit_hit  = sample_tick && (tick_q == LAST);
  assign last_bit = bit_q == ({1'b0, dbits_q} + 3'(DATA_BITS_OFFSET - 1));
  assign par_en   = (ptype_q == PAR_EVEN) || (ptype_q == PAR_ODD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dbits_q <= '0;
      ptype_q <= PAR_NONE;
      dstop_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      if (sample_tick) tick_q <= tick_q + TW'(1);
      unique case (state_q)
        IDLE: begin
          if (sample_tick && !rxs) begin
            dbits_q <= data_bits_count;
            ptype_q <= parity_e'(parity_type);
            dstop_q <= double_stop_bits;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            tick_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (mid_hit) begin
            if (rxs) begin
              state_q <= IDLE;
            end else begin
              tick_q  <= '0;
              bit_q   <= '0;
              shift_q <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_hit) begin
            shift_q[bit_q] <= rxs;
            if (last_bit) begin
              state_q <= par_en ? PARITY : STOP1;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        PARITY: begin
          // even: any odd total is an error; odd: the inverse
          if (bit_hit) begin
            perr_q  <= (^shift_q) ^ rxs ^ (ptype_q == PAR_ODD);
            state_q <= STOP1;
          end
        end
        STOP1: begin
          if (bit_hit) begin
            ferr_q  <= !rxs;
            state_q <= dstop_q ? STOP2 : DONE;
          end
        end
        STOP2: begin
          if (bit_hit) begin
            ferr_q  <= ferr_q | !rxs;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!fifo_full) begin
            valid_q <= 1'b1;
            data_q  <= shift_q;
            pe_q    <= perr_q;
            fe_q    <= ferr_q;
          end else begin
            ovr_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
